branch_predictor: RTL and testbench

//   Dynamic branch predictor and branch target buffer (BTB) for the pipelined MIPS core.

---
 rtl/branch_predictor.sv | 149 ++++++++++++++
 tb/tb_branch_predictor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Dynamic branch predictor + BTB: 2-bit counters, tagged targets, optional gshare indexing (BP_GSHARE_EN).
// Latency: prediction and mispredict report are combinational; table updates are visible the cycle after the edge.
// Backpressure: none; a lookup is answered every cycle and an update is accepted whenever upd_valid_i is high.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int ADDR_W  = 32,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  output logic [IDX_W-1:0]  pred_ghr_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [ADDR_W-1:0] upd_pred_target_i,
  input  logic [IDX_W-1:0]  upd_ghr_i,
  output logic              mispredict_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic [CNT_W-1:0]  br_count_o,
  output logic [CNT_W-1:0]  miss_count_o
);

  localparam int TAG_LO = IDX_W + 2;

  // Table storage
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]   lk_idx, up_idx;
  logic [TAG_W-1:0]   lk_tag, up_tag;
  logic               lk_hit, up_hit, wr_en;
  logic [1:0]         ctr_d;
  logic [ADDR_W-1:0]  target_d;

  assign lk_tag = lookup_pc_i[TAG_LO+TAG_W-1:TAG_LO];
  assign up_tag = upd_pc_i[TAG_LO+TAG_W-1:TAG_LO];

`ifdef BP_GSHARE_EN
  // History only advances on resolved branches, so no repair is needed on a flush.
  logic [IDX_W-1:0] ghr_q, ghr_d;

  assign lk_idx     = lookup_pc_i[IDX_W+1:2] ^ ghr_q;
  assign up_idx     = upd_pc_i[IDX_W+1:2] ^ upd_ghr_i;
  assign pred_ghr_o = ghr_q;
  assign ghr_d      = upd_valid_i ? {ghr_q[IDX_W-2:0], upd_taken_i} : ghr_q;

  // Global history register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ghr_q <= '0;
    else        ghr_q <= ghr_d;
  end
`else
  logic unused_ghr;

  assign lk_idx     = lookup_pc_i[IDX_W+1:2];
  assign up_idx     = upd_pc_i[IDX_W+1:2];
  assign pred_ghr_o = '0;
  assign unused_ghr = ^upd_ghr_i;
`endif

  // Lookup reads pre-update contents; a same-cycle write to this index is not bypassed.
  assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken_o  = lk_hit && ctr_q[lk_idx][1];
  assign pred_target_o = pred_taken_o ? target_q[lk_idx] : lookup_pc_i + ADDR_W'(4);

  // Mispredict detection and redirect target for the resolving branch
  always_comb begin
    mispredict_o  = 1'b0;
    redirect_pc_o = '0;
    if (upd_valid_i) begin
      mispredict_o  = (upd_taken_i != upd_pred_taken_i) ||
                      (upd_taken_i && (upd_target_i != upd_pred_target_i));
      redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + ADDR_W'(4);
    end
  end

  // A miss that is not taken leaves the table alone; every other update writes the entry.
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign wr_en  = upd_valid_i && (up_hit || upd_taken_i);

  // Next entry contents: train counter on hit, allocate weakly-taken on a taken miss
  always_comb begin
    ctr_d    = ctr_q[up_idx];
    target_d = target_q[up_idx];
    if (up_hit) begin
      if (upd_taken_i) begin
        ctr_d    = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'b01;
        target_d = upd_target_i;
      end else begin
        ctr_d    = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'b01;
      end
    end else begin
      ctr_d    = 2'b10;
      target_d = upd_target_i;
    end
  end

  // Table write; reset leaves every counter weakly not-taken
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (wr_en) begin
      valid_q[up_idx]  <= 1'b1;
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= target_d;
      ctr_q[up_idx]    <= ctr_d;
    end
  end

  // Saturating statistics
  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (upd_valid_i && (br_cnt_q != '1))                   br_cnt_d   = br_cnt_q + 1'b1;
    if (upd_valid_i && mispredict_o && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 1'b1;
  end

  // Statistics registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign br_count_o   = br_cnt_q;
  assign miss_count_o = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=16, narrow statistics counters so saturation is reachable).
// Expected values are queued when stimulus is driven and popped when the outputs are sampled.
// Inputs change on the falling edge; outputs are sampled shortly after, away from the rising edge.
module tb_branch_predictor;
  localparam int ENTRIES = 16;
  localparam int ADDR_W  = 32;
  localparam int TAG_W   = 8;
  localparam int CNT_W   = 5;
  localparam int IDX_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] lookup_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic [IDX_W-1:0]  pred_ghr;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_pred_taken;
  logic [ADDR_W-1:0] upd_pred_target;
  logic [IDX_W-1:0]  upd_ghr;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W-1:0]  br_count;
  logic [CNT_W-1:0]  miss_count;

  int checks = 0;
  int errors = 0;
  int br_m   = 0;
  int miss_m = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  branch_predictor #(
    .ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst_n),
    .lookup_pc_i(lookup_pc), .pred_taken_o(pred_taken), .pred_target_o(pred_target),
    .pred_ghr_o(pred_ghr),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred_taken),
    .upd_pred_target_i(upd_pred_target), .upd_ghr_i(upd_ghr),
    .mispredict_o(mispredict), .redirect_pc_o(redirect_pc),
    .br_count_o(br_count), .miss_count_o(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty observed=%0h required=<queued value>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic lookup(input logic [31:0] pc, input logic et, input logic [31:0] etgt, input string t);
    lookup_pc = pc;
    push({t, "_taken"}, {31'd0, et});
    push({t, "_target"}, etgt);
    #1;
    pop_chk({31'd0, pred_taken});
    pop_chk(pred_target);
  endtask

  task automatic check_counts(input string t);
    push({t, "_br"}, br_m);
    push({t, "_miss"}, miss_m);
    pop_chk({27'd0, br_count});
    pop_chk({27'd0, miss_count});
  endtask

  // One resolved branch: check mispredict/redirect before the edge, counters after it.
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic ptk, input logic [31:0] ptgt,
                     input logic emis, input logic [31:0] eredir, input string t);
    @(negedge clk);
    upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt; upd_valid = 1'b1;
    push({t, "_mis"}, {31'd0, emis});
    push({t, "_redir"}, eredir);
    #1;
    pop_chk({31'd0, mispredict});
    pop_chk(redirect_pc);
    br_m = (br_m == CMAX) ? CMAX : br_m + 1;
    if (emis) miss_m = (miss_m == CMAX) ? CMAX : miss_m + 1;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    #1;
    check_counts(t);
  endtask

  // Reset asserted while an update is being presented across a clock edge
  task automatic reset_mid_update(input logic [31:0] pc, input string t);
    @(negedge clk);
    upd_pc = pc; upd_taken = 1'b1; upd_target = 32'h0000_0700;
    upd_pred_taken = 1'b0; upd_pred_target = pc + 32'd4; upd_valid = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    br_m = 0; miss_m = 0;
    check_counts(t);
    push({t, "_ghr"}, 32'd0);
    pop_chk({28'd0, pred_ghr});
    lookup(pc, 1'b0, pc + 32'd4, {t, "_lk"});
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    lookup_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_pred_taken = 1'b0; upd_pred_target = '0; upd_ghr = '0;

    // Reset state
    #12;
    check_counts("rst");
    push("rst_ghr", 32'd0);
    pop_chk({28'd0, pred_ghr});
    lookup(32'h0000_0040, 1'b0, 32'h0000_0044, "rst_lk40");
    @(negedge clk);
    rst_n = 1'b1;

`ifndef BP_GSHARE_EN
    // First taken branch allocates and redirects
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b1, 32'h100, "alloc40");
    lookup(32'h40, 1'b1, 32'h100, "lk40_c2");

    // Training down: 2 -> 1 -> 0, then back up 0 -> 1 -> 2 -> 3 (sat)
    upd(32'h40, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h44, "nt1");
    lookup(32'h40, 1'b0, 32'h44, "lk40_c1");
    upd(32'h40, 1'b0, 32'h100, 1'b0, 32'h44, 1'b0, 32'h44, "nt2");
    lookup(32'h40, 1'b0, 32'h44, "lk40_c0");
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b1, 32'h100, "t_from0");
    lookup(32'h40, 1'b0, 32'h44, "lk40_sat0");
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b1, 32'h100, "t_to2");
    lookup(32'h40, 1'b1, 32'h100, "lk40_c2b");
    upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h100, "t_to3");
    upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h100, "t_sat3");
    upd(32'h40, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h44, "nt_from3");
    lookup(32'h40, 1'b1, 32'h100, "lk40_sat3");

    // Alias: same index, different tag, overwrites entry
    upd(32'h440, 1'b1, 32'h200, 1'b0, 32'h444, 1'b1, 32'h200, "alloc440");
    lookup(32'h40, 1'b0, 32'h44, "lk40_alias");
    lookup(32'h440, 1'b1, 32'h200, "lk440");

    // Miss not taken leaves the table unchanged
    upd(32'h80, 1'b0, 32'h0, 1'b0, 32'h84, 1'b0, 32'h84, "miss_nt");
    lookup(32'h440, 1'b1, 32'h200, "lk440_kept");
    lookup(32'h80, 1'b0, 32'h84, "lk80_nt");

    // Hit taken with new target; hit not-taken keeps target
    upd(32'h440, 1'b1, 32'h240, 1'b1, 32'h200, 1'b1, 32'h240, "tgt_change");
    lookup(32'h440, 1'b1, 32'h240, "lk440_new");
    upd(32'h440, 1'b0, 32'h998, 1'b1, 32'h240, 1'b1, 32'h444, "nt_keep");
    lookup(32'h440, 1'b1, 32'h240, "lk440_keep");

    // Same-cycle lookup and update to one index: lookup sees old contents
    @(negedge clk);
    lookup_pc = 32'h80;
    upd_pc = 32'h80; upd_taken = 1'b1; upd_target = 32'h300;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h84; upd_valid = 1'b1;
    push("nobyp_taken", 32'd0);
    push("nobyp_target", 32'h84);
    push("nobyp_mis", 32'd1);
    #1;
    pop_chk({31'd0, pred_taken});
    pop_chk(pred_target);
    pop_chk({31'd0, mispredict});
    br_m++; miss_m++;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    lookup(32'h80, 1'b1, 32'h300, "nobyp_after");
    check_counts("nobyp");

    // Wrapping fall-through address
    lookup(32'hFFFF_FFFC, 1'b0, 32'h0000_0000, "wrap");

    // Idle update port reports nothing
    @(negedge clk);
    upd_taken = 1'b1; upd_target = 32'h1234; upd_pred_taken = 1'b0; upd_pc = 32'h500;
    push("idle_mis", 32'd0);
    push("idle_redir", 32'd0);
    #1;
    pop_chk({31'd0, mispredict});
    pop_chk(redirect_pc);

    // Drive both statistics counters into saturation
    for (int i = 0; i < CMAX + 4; i++)
      upd(32'h100, 1'b1, 32'h500, 1'b0, 32'h104, 1'b1, 32'h500, "sat");
    push("sat_br_final", CMAX);
    push("sat_miss_final", CMAX);
    pop_chk({27'd0, br_count});
    pop_chk({27'd0, miss_count});

    // Reset while an update is in flight clears everything
    reset_mid_update(32'h440, "rst_mid");
    lookup(32'h100, 1'b0, 32'h104, "rst_lk100");
    lookup(32'h80, 1'b0, 32'h84, "rst_lk80");
`else
    // Gshare: history shifts in each resolved taken outcome
    upd_ghr = 4'h0;
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b1, 32'h100, "g1");
    push("ghr1", 32'h1);
    pop_chk({28'd0, pred_ghr});
    upd_ghr = 4'h1;
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b1, 32'h100, "g2");
    push("ghr3", 32'h3);
    pop_chk({28'd0, pred_ghr});
    upd_ghr = 4'h3;
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b1, 32'h100, "g3");
    push("ghr7", 32'h7);
    pop_chk({28'd0, pred_ghr});
    lookup(32'h40, 1'b0, 32'h44, "g_lk40_idx7");
    lookup(32'h1C, 1'b0, 32'h20, "g_lk1c_tagdiff");
    reset_mid_update(32'h40, "g_rst_mid");
    lookup(32'h44, 1'b0, 32'h48, "g_rst_lk44");
`endif

    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
